// File: rtl/kb_scan_sequencer.sv
// PS/2 keyboard receiver: line synchronizer, 11-bit frame checker, E0/F0 prefix folding,
// shift/caps tracking and a small event FIFO with a valid/ready handshake.
module kb_scan_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 50000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code_o,
    output logic       brk_o,
    output logic       ext_o,
    output logic       code_valid,
    input  logic       code_ready,
    output logic       shift_o,
    output logic       caps_o,
    output logic       err_o,
    output logic       ovf_o,
    input  logic       ovf_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_BRK   = 8'hF0;
    localparam logic [7:0] CODE_LSHFT = 8'h12;
    localparam logic [7:0] CODE_RSHFT = 8'h59;
    localparam logic [7:0] CODE_CAPS  = 8'h58;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } event_t;

    // ---------------- synchronizer and falling-edge strobe ----------------
    logic [SYNC_STAGES-1:0] clk_sync, data_sync;
    logic                   clk_prev, strobe, bit_in;

    // Sync flops reset high: an idle PS/2 line is high, so no false edge on release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
            strobe    <= 1'b0;
            bit_in    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments here let every flop sample the pre-edge value;
            // blocking ones would collapse the synchronizer chain into a single stage.
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
            strobe    <= clk_prev & ~clk_sync[SYNC_STAGES-1];
            bit_in    <= data_sync[SYNC_STAGES-1];
        end
    end

    // ---------------- frame FSM, decode and modifiers ----------------
    state_t        state;
    logic [7:0]    shreg;
    logic [2:0]    bit_cnt;
    logic          par_bit;
    logic [TW-1:0] to_cnt;
    logic          ext_pend, brk_pend;
    logic          lshift, rshift;

    logic   frame_done, frame_good, timeout_hit, push, pop, full, wr_en;
    event_t ev_in, head;

    logic [AW:0]   count;
    logic [AW-1:0] wr_ptr, rd_ptr;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        frame_done  = 1'b0;
        frame_good  = 1'b0;
        timeout_hit = 1'b0;
        push        = 1'b0;
        ev_in       = '{ext: ext_pend, brk: brk_pend, code: shreg};
        if (strobe && state == S_STOP) begin
            frame_done = 1'b1;
            frame_good = (^{shreg, par_bit}) && bit_in;
        end
        if (state != S_IDLE && !strobe && to_cnt == TO_LAST)
            timeout_hit = 1'b1;
        if (frame_good && shreg != CODE_EXT && shreg != CODE_BRK)
            push = 1'b1;
    end

    assign pop   = code_valid && code_ready;
    assign full  = (count == (AW+1)'(FIFO_DEPTH));
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            par_bit  <= 1'b0;
            to_cnt   <= '0;
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
            lshift   <= 1'b0;
            rshift   <= 1'b0;
            caps_o   <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            err_o <= (frame_done && !frame_good) || timeout_hit;

            if (state == S_IDLE || strobe || timeout_hit)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + TW'(1);

            // A timeout drops the partial byte but keeps any pending prefixes.
            if (timeout_hit) begin
                state <= S_IDLE;
            end else if (strobe) begin
                case (state)
                    S_IDLE: begin
                        if (!bit_in) begin
                            state   <= S_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    S_DATA: begin
                        shreg   <= {bit_in, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            state <= S_PARITY;
                    end
                    S_PARITY: begin
                        par_bit <= bit_in;
                        state   <= S_STOP;
                    end
                    S_STOP: begin
                        state <= S_IDLE;
                        if (frame_good) begin
                            if (shreg == CODE_EXT) begin
                                ext_pend <= 1'b1;
                            end else if (shreg == CODE_BRK) begin
                                brk_pend <= 1'b1;
                            end else begin
                                ext_pend <= 1'b0;
                                brk_pend <= 1'b0;
                                if (!ext_pend) begin
                                    if (shreg == CODE_LSHFT) lshift <= !brk_pend;
                                    if (shreg == CODE_RSHFT) rshift <= !brk_pend;
                                    if (shreg == CODE_CAPS && !brk_pend) caps_o <= !caps_o;
                                end
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign shift_o = lshift | rshift;

    // ---------------- event FIFO ----------------
    event_t mem [FIFO_DEPTH];

    // NOTE: the storage array has no reset; only pointers and count need a known
    // state, and the outputs are gated by code_valid so stale entries never show.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= ev_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_o  <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            // Set beats clear when a drop and ovf_clr coincide.
            if (push && !wr_en)
                ovf_o <= 1'b1;
            else if (ovf_clr)
                ovf_o <= 1'b0;
        end
    end

    assign head       = mem[rd_ptr];
    assign code_valid = (count != '0);
    assign code_o     = code_valid ? head.code : 8'h00;
    assign brk_o      = code_valid & head.brk;
    assign ext_o      = code_valid & head.ext;

endmodule

// File: tb/tb_kb_scan_sequencer.sv
// Directed bench for kb_scan_sequencer: table of single frames with expected events and
// modifier state, plus hand sequences for timeout, backpressure/overflow and mid-frame reset.
module tb_kb_scan_sequencer;

    localparam int TO   = 300;
    localparam int HALF = 25;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       ps2_clk = 1'b1, ps2_data = 1'b1;
    logic       code_ready = 1'b0, ovf_clr = 1'b0;
    logic [7:0] code_o;
    logic       brk_o, ext_o, code_valid, shift_o, caps_o, err_o, ovf_o;

    kb_scan_sequencer #(.SYNC_STAGES(2), .TIMEOUT_CYC(TO), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .code_o(code_o), .brk_o(brk_o), .ext_o(ext_o), .code_valid(code_valid),
        .code_ready(code_ready), .shift_o(shift_o), .caps_o(caps_o), .err_o(err_o),
        .ovf_o(ovf_o), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    // Flag order: par_bad stop push ext brk err shift caps
    typedef struct packed {
        logic [7:0] data;
        logic par_bad, stop, push, ext, brk, err, shift, caps;
    } vec_t;

    int tests = 0, fails = 0;
    int cyc = 0, err_cnt = 0;
    logic [9:0] got[$];

    always @(posedge clk) cyc++;

    // Consumer-side monitor: records accepted events and counts err_o high cycles.
    always @(negedge clk) begin
        if (err_o) err_cnt++;
        if (code_valid && code_ready) got.push_back({ext_o, brk_o, code_o});
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        idle(HALF);
        ps2_clk = 1'b0;
        idle(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_bad, input logic stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit((~^d) ^ par_bad);
        ps2_bit(stop);
        ps2_data = 1'b1;
        idle(4 * HALF);
    endtask

    task automatic expect_event(input string name, input logic [9:0] exp);
        logic [9:0] ev;
        check({name, "_cnt"}, got.size(), 1);
        if (got.size() > 0) begin
            ev = got.pop_front();
            check({name, "_ev"}, ev, exp);
        end
        got.delete();
    endtask

    vec_t vecs[23];
    logic [7:0] bp_codes[5];

    initial begin
        int e0, t0, lat;
        logic [9:0] ev;

        vecs[0]  = {8'h1C, 8'b0110_0000};
        vecs[1]  = {8'hF0, 8'b0100_0000};
        vecs[2]  = {8'h1C, 8'b0110_1000};
        vecs[3]  = {8'hE0, 8'b0100_0000};
        vecs[4]  = {8'h75, 8'b0111_0000};
        vecs[5]  = {8'hE0, 8'b0100_0000};
        vecs[6]  = {8'hF0, 8'b0100_0000};
        vecs[7]  = {8'h75, 8'b0111_1000};
        vecs[8]  = {8'h12, 8'b0110_0010};
        vecs[9]  = {8'h59, 8'b0110_0010};
        vecs[10] = {8'hF0, 8'b0100_0010};
        vecs[11] = {8'h12, 8'b0110_1010};
        vecs[12] = {8'hF0, 8'b0100_0010};
        vecs[13] = {8'h59, 8'b0110_1000};
        vecs[14] = {8'h58, 8'b0110_0001};
        vecs[15] = {8'hF0, 8'b0100_0001};
        vecs[16] = {8'h58, 8'b0110_1001};
        vecs[17] = {8'h58, 8'b0110_0000};
        vecs[18] = {8'h1C, 8'b1100_0100};
        vecs[19] = {8'h1C, 8'b0000_0100};
        vecs[20] = {8'hE0, 8'b0100_0000};
        vecs[21] = {8'h12, 8'b0111_0000};
        vecs[22] = {8'h1C, 8'b0110_0000};
        bp_codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};

        // Reset state, during and after reset
        idle(3);
        check("rst_outputs", {code_valid, code_o, brk_o, ext_o, shift_o, caps_o, err_o, ovf_o}, 0);
        rst_n = 1'b1;
        idle(5);
        check("post_rst_outputs", {code_valid, code_o, brk_o, ext_o, shift_o, caps_o, err_o, ovf_o}, 0);

        // Table: one frame per record, consumer always ready
        code_ready = 1'b1;
        for (int i = 0; i < 23; i++) begin
            e0 = err_cnt;
            send_frame(vecs[i].data, vecs[i].par_bad, vecs[i].stop);
            check($sformatf("v%0d_push", i), got.size(), {31'd0, vecs[i].push});
            if (vecs[i].push && got.size() > 0) begin
                ev = got.pop_front();
                check($sformatf("v%0d_event", i), ev, {vecs[i].ext, vecs[i].brk, vecs[i].data});
            end
            got.delete();
            check($sformatf("v%0d_err", i), err_cnt - e0, {31'd0, vecs[i].err});
            check($sformatf("v%0d_shift", i), shift_o, vecs[i].shift);
            check($sformatf("v%0d_caps", i), caps_o, vecs[i].caps);
        end

        // Timeout: start bit + 4 data bits, then the keyboard clock stops
        e0 = err_cnt;
        ps2_bit(1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        idle(HALF);
        ps2_clk = 1'b0;
        t0 = cyc;
        idle(HALF);
        ps2_clk = 1'b1;
        for (int k = 0; k < TO + 50; k++) begin
            @(negedge clk);
            if (err_o) break;
        end
        lat = cyc - t0;
        check("timeout_seen", err_o, 1);
        check("timeout_latency", (lat >= TO && lat <= TO + 8), 1);
        idle(20);
        check("timeout_err_once", err_cnt - e0, 1);
        check("timeout_no_event", got.size(), 0);
        send_frame(8'h1C, 1'b0, 1'b1);
        expect_event("after_timeout", {2'b00, 8'h1C});

        // Backpressure: 5 makes into a 4-deep FIFO with the consumer stalled
        code_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_frame(bp_codes[i], 1'b0, 1'b1);
        check("bp_valid", code_valid, 1);
        check("bp_ovf", ovf_o, 1);
        check("bp_head", code_o, 8'h15);
        check("bp_nothing_taken", got.size(), 0);
        code_ready = 1'b1;
        idle(10);
        check("bp_drain_cnt", got.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (got.size() > 0) begin
                ev = got.pop_front();
                check($sformatf("bp_order%0d", i), ev, {2'b00, bp_codes[i]});
            end
        end
        got.delete();
        check("bp_empty", code_valid, 0);
        check("ovf_sticky", ovf_o, 1);
        ovf_clr = 1'b1;
        idle(1);
        ovf_clr = 1'b0;
        idle(1);
        check("ovf_cleared", ovf_o, 0);

        // Reset mid-frame with an event buffered and caps on
        code_ready = 1'b0;
        send_frame(8'h58, 1'b0, 1'b1);
        check("pre_rst_caps", caps_o, 1);
        check("pre_rst_valid", code_valid, 1);
        ps2_bit(1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b0);
        ps2_data = 1'b1;
        idle(5);
        rst_n = 1'b0;
        idle(3);
        check("midrst_outputs", {code_valid, code_o, brk_o, ext_o, shift_o, caps_o, err_o, ovf_o}, 0);
        idle(5);
        rst_n = 1'b1;
        e0 = err_cnt;
        idle(4 * HALF);
        check("midrst_no_err", err_cnt - e0, 0);
        check("midrst_no_valid", code_valid, 0);
        code_ready = 1'b1;
        send_frame(8'h1C, 1'b0, 1'b1);
        expect_event("after_rst", {2'b00, 8'h1C});
        check("after_rst_caps", caps_o, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
